cellrv32_io_arbiter: RTL
========================

// Module: cellrv32_io_arbiter
// PURPOSE
//  Shares the processor-internal IO device bus (SYSINFO and peripherals) between two hosts:
//  A = CPU data port, B = on-chip debugger / DMA. Each host issues single-cycle rden/wren strobes.
//  Each host has a one-entry pending buffer. Requests are serialised to the device bus and
//  responses are routed back to the owner. A bus timeout turns a missing device ack into err.
// PARAMETERS
//  PRIO_MODE   0    0 = fixed priority (A wins), 1 = round-robin (host not served last wins)
//  TMO_EN      1'b1 enable bus-timeout error generation
//  TMO_CYCLES  255  device-response window in cycles, counted from the device strobe (>= 2)
// PORTS
//  clk_i       in   1   global clock line, rising edge
//  rst_i       in   1   reset; synchronous, active-high
//  a_addr_i    in   32  host A address (B: b_addr_i, identical set for all host ports)
//  a_rden_i    in   1   host A read strobe
//  a_wren_i    in   1   host A write strobe
//  a_ben_i     in   4   host A byte enable
//  a_data_i    in   32  host A write data
//  a_data_o    out  32  host A read data, valid with a_ack_o, else 0
//  a_ack_o     out  1   host A transfer acknowledge
//  a_err_o     out  1   host A transfer error (device err, timeout or illegal strobe)
//  d_addr_o    out  32  device address
//  d_rden_o    out  1   device read strobe
//  d_wren_o    out  1   device write strobe
//  d_ben_o     out  4   device byte enable
//  d_data_o    out  32  device write data
//  d_data_i    in   32  device read data
//  d_ack_i     in   1   device acknowledge
//  d_err_i     in   1   device error
// BEHAVIOUR
//  - Reset:
//    - All outputs 0.
//    - Both slots empty, FSM IDLE, timeout counter 0, RR pointer = A.
//  - Capture:
//    - Host strobe at cycle T with its slot empty: {addr,data,ben,rw} is latched; slot valid from T+1.
//    - Strobe while the slot is full is ignored (no capture, no response).
//    - rden & wren in the same cycle is illegal: nothing is captured; that host's err_o pulses at T+1.
//  - FSM:
//    - IDLE: if any slot valid, pick the owner per PRIO_MODE -> ISSUE.
//    - ISSUE: one cycle. Drive d_rden_o or d_wren_o = 1. Clear the owner slot. Timeout cnt = 0 -> WAIT.
//    - WAIT, device side:
//      - d_addr_o, d_data_o and d_ben_o hold stable; strobes are 0.
//      - On d_ack_i or d_err_i -> IDLE.
//      - TMO_EN and cnt == TMO_CYCLES-1 with no ack/err -> IDLE.
//    - WAIT, owner response (combinational, same cycle):
//      - ack_o = d_ack_i; err_o = d_err_i | timeout.
//      - data_o = d_data_i when d_ack_i & read, else 0.
//  - Latency:
//    - Host strobe T -> device strobe T+2 -> earliest host ack T+3 (1-cycle device).
//    - Back-to-back: completion at N -> next device strobe N+2.
//  - Simultaneous events:
//    - d_ack_i and timeout in the same cycle: ack wins; err_o = d_err_i only.
//    - d_ack_i with d_err_i: both forwarded.
//    - A host strobe in the completion cycle of its own request is accepted (its slot is already empty).
//  - Non-owner outputs:
//    - Non-owner ack_o/err_o/data_o stay 0.
//    - d_ack_i/d_err_i outside WAIT (late ack after timeout) are discarded.
//  - Round-robin: the pointer flips to the other host at every ISSUE.
//  - Reset mid-transfer: slots drop and the FSM goes to IDLE; no ack/err is produced for lost requests.
//  - Timeout counter: 8..32-bit wide (clog2(TMO_CYCLES)); saturates, never wraps.
// STRUCTURE
//  - cellrv32_package:
//    - io_req_t {addr[31:0], data[31:0], ben[3:0], rw}
//    - io_arb_state_t {IDLE, ISSUE, WAIT}
//    - io_host_a_c / io_host_b_c
//  - Sub-module cellrv32_io_arbiter_slot: one-entry pending buffer plus illegal-strobe
//    detection; instantiated twice.
// TESTING
//  - A read to sysinfo_base_c, strobe cycle 10:
//    - d_rden_o at 12.
//    - a_ack_o at 13, a_data_o = CLOCK_FREQUENCY.
//  - A and B strobe at cycle 10, PRIO_MODE=0:
//    - A issued at 12, B issued after A completes.
//    - PRIO_MODE=1: 4 mixed pairs alternate A,B,A,B.
//  - TMO_CYCLES=16, device never acks, strobe cycle 10:
//    - a_err_o = 1 at cycle 27 only; FSM IDLE at 28.
//    - A d_ack_i injected at 30 gives no host response.
//  - B strobe while the B slot is full:
//    - Dropped; exactly one b_ack_o.
//    - rden & wren together -> b_err_o next cycle, no device strobe.
//  - rst_i=1 in WAIT with both slots full:
//    - All outputs 0 next cycle.
//    - No ack/err afterwards; a new A request completes normally.
//  - Write to SYSINFO (device err_o):
//    - a_err_o = 1 and a_ack_o = 1 in the same cycle.
//    - a_data_o = 0.

Source files
------------

// File: rtl/cellrv32_io_arbiter_pkg.sv
// rtl/cellrv32_io_arbiter_pkg.sv - shared types and constants for the IO bus arbiter
package cellrv32_package;

    localparam logic io_host_a_c = 1'b0;
    localparam logic io_host_b_c = 1'b1;

    localparam logic [31:0] sysinfo_base_c = 32'hFFFF_FFE0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic        rw;
    } io_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } io_arb_state_t;

    // Counter width: clog2 of the window, kept within 8..32 bits.
    function automatic int tmo_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 8) begin
            w = 8;
        end
        if (w > 32) begin
            w = 32;
        end
        return w;
    endfunction

endpackage

// File: rtl/cellrv32_io_arbiter_slot.sv
// rtl/cellrv32_io_arbiter_slot.sv - one-entry host request buffer with illegal-strobe flag
module cellrv32_io_arbiter_slot
    import cellrv32_package::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rden,
    input  logic        wren,
    input  logic [3:0]  ben,
    input  logic [31:0] data,
    input  logic        clr,
    output logic        valid,
    output io_req_t     req,
    output logic        ill
);

    // A strobe into a full slot is dropped silently; clr only ever hits a full slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            req   <= '0;
            ill   <= 1'b0;
        end else begin
            ill <= rden & wren;
            if (!valid && (rden ^ wren)) begin
                valid    <= 1'b1;
                req.addr <= addr;
                req.data <= data;
                req.ben  <= ben;
                req.rw   <= wren;
            end else if (clr) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cellrv32_io_arbiter.sv
// rtl/cellrv32_io_arbiter.sv - two-host arbiter for the processor-internal IO device bus
module cellrv32_io_arbiter
    import cellrv32_package::*;
#(
    parameter int   PRIO_MODE  = 0,
    parameter logic TMO_EN     = 1'b1,
    parameter int   TMO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_addr_i,
    input  logic        a_rden_i,
    input  logic        a_wren_i,
    input  logic [3:0]  a_ben_i,
    input  logic [31:0] a_data_i,
    output logic [31:0] a_data_o,
    output logic        a_ack_o,
    output logic        a_err_o,
    input  logic [31:0] b_addr_i,
    input  logic        b_rden_i,
    input  logic        b_wren_i,
    input  logic [3:0]  b_ben_i,
    input  logic [31:0] b_data_i,
    output logic [31:0] b_data_o,
    output logic        b_ack_o,
    output logic        b_err_o,
    output logic [31:0] d_addr_o,
    output logic        d_rden_o,
    output logic        d_wren_o,
    output logic [3:0]  d_ben_o,
    output logic [31:0] d_data_o,
    input  logic [31:0] d_data_i,
    input  logic        d_ack_i,
    input  logic        d_err_i
);

    localparam int            CW       = tmo_width(TMO_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

    io_arb_state_t state, state_nxt;
    logic          owner, owner_nxt, rr_ptr;
    io_req_t       cur, a_req, b_req;
    logic          a_valid, b_valid, a_ill, b_ill;
    logic [CW-1:0] cnt;
    logic          tmo, rsp_ack, rsp_err;
    logic [31:0]   rsp_data;

    cellrv32_io_arbiter_slot slot_a (
        .clk(clk_i), .rst(rst_i),
        .addr(a_addr_i), .rden(a_rden_i), .wren(a_wren_i), .ben(a_ben_i), .data(a_data_i),
        .clr(state == ISSUE && owner == io_host_a_c),
        .valid(a_valid), .req(a_req), .ill(a_ill)
    );

    cellrv32_io_arbiter_slot slot_b (
        .clk(clk_i), .rst(rst_i),
        .addr(b_addr_i), .rden(b_rden_i), .wren(b_wren_i), .ben(b_ben_i), .data(b_data_i),
        .clr(state == ISSUE && owner == io_host_b_c),
        .valid(b_valid), .req(b_req), .ill(b_ill)
    );

    // An ack in the last window cycle still wins over the timeout.
    assign tmo = TMO_EN && (state == WAIT) && (cnt == TMO_LAST) && !d_ack_i;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    if (a_valid && b_valid) begin
                        owner_nxt = (PRIO_MODE == 1) ? rr_ptr : io_host_a_c;
                    end else begin
                        owner_nxt = b_valid ? io_host_b_c : io_host_a_c;
                    end
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (d_ack_i || d_err_i || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt reads 0 in the ISSUE cycle, so the window is measured from the device strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            owner  <= io_host_a_c;
            rr_ptr <= io_host_a_c;
            cur    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (state == IDLE && state_nxt == ISSUE) begin
                cur <= (owner_nxt == io_host_b_c) ? b_req : a_req;
            end
            if (state == ISSUE) begin
                rr_ptr <= ~owner;
            end
            if (state == ISSUE || state == WAIT) begin
                if (cnt != '1) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        d_rden_o = (state == ISSUE) && !cur.rw;
        d_wren_o = (state == ISSUE) && cur.rw;
        d_addr_o = cur.addr;
        d_data_o = cur.data;
        d_ben_o  = cur.ben;
        rsp_ack  = (state == WAIT) && d_ack_i;
        rsp_err  = (state == WAIT) && (d_err_i || tmo);
        rsp_data = (rsp_ack && !cur.rw) ? d_data_i : 32'h0;
        a_ack_o  = rsp_ack && (owner == io_host_a_c);
        a_err_o  = a_ill || (rsp_err && (owner == io_host_a_c));
        a_data_o = (owner == io_host_a_c) ? rsp_data : 32'h0;
        b_ack_o  = rsp_ack && (owner == io_host_b_c);
        b_err_o  = b_ill || (rsp_err && (owner == io_host_b_c));
        b_data_o = (owner == io_host_b_c) ? rsp_data : 32'h0;
    end

endmodule
